// File: rtl/mem_access_if.sv
// Data-memory bus between mem_access (master) and a memory (slave).
//
// Handshake: the master raises dmem_req with dmem_we/addr/wstrb/wdata and
// holds all of them stable until it samples dmem_ack=1 on a rising edge;
// dmem_ack and dmem_rdata are meaningful only while dmem_req=1, and the
// request drops in the cycle after the acknowledging edge.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: turns one ALU-stage memory operation into a single
// word-aligned data-memory request, aligns store lanes, extracts and extends
// load data, and aborts a request that is not acknowledged in time.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses complete
// with err=1 and no bus request instead of being silently aligned down.
// Store operations return load_data=0.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        store_data,
    mem_access_if.master       bus,
    output logic               busy,
    output logic               done,
    output logic [31:0]        load_data,
    output logic               err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] sd_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [15:0] cnt_q;
    logic [31:0] load_q;
    logic        err_q;

    logic        is_noop;
    logic        is_illegal;
    logic        is_misalign;
    logic        start_bad;
    logic        timeout_hit;
    logic        accept;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    assign accept     = (state == S_IDLE) && start;
    assign is_noop    = !mem_read && !mem_write;
    assign is_illegal = (mem_read && mem_write) || (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
    assign is_misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                         ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
`else
    assign is_misalign = 1'b0;
`endif
    // A no-op never traps on alignment; an illegal encoding always wins.
    assign start_bad   = is_illegal || (!is_noop && is_misalign);
    assign timeout_hit = (cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: skip REQ for no-op/illegal, leave REQ on ack or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (start_bad || is_noop) ? S_DONE : S_REQ;
            S_REQ:   if (bus.dmem_ack || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operation latch, timeout counter and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            sd_q   <= '0;
            f3_q   <= '0;
            we_q   <= 1'b0;
            cnt_q  <= '0;
            load_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            addr_q <= alu_result;
            sd_q   <= store_data;
            f3_q   <= funct3;
            we_q   <= mem_write;
            cnt_q  <= '0;
            if (start_bad || is_noop) begin
                load_q <= '0;
                err_q  <= start_bad;
            end
        end else if (state == S_REQ) begin
            if (bus.dmem_ack) begin
                load_q <= we_q ? 32'h0 : load_ext;
                err_q  <= 1'b0;
            end else if (timeout_hit) begin
                load_q <= '0;
                err_q  <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 16'd1;
            end
        end
    end

    // Store lane placement from the latched address and size.
    always_comb begin
        strb  = 4'b1111;
        wdata = sd_q;
        case (f3_q[1:0])
            2'b00: begin
                strb  = 4'b0001 << addr_q[1:0];
                wdata = {4{sd_q[7:0]}};
            end
            2'b01: begin
                strb  = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sd_q[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = sd_q;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        rd_byte = bus.dmem_rdata[7:0];
        case (addr_q[1:0])
            2'b00: rd_byte = bus.dmem_rdata[7:0];
            2'b01: rd_byte = bus.dmem_rdata[15:8];
            2'b10: rd_byte = bus.dmem_rdata[23:16];
            2'b11: rd_byte = bus.dmem_rdata[31:24];
            default: rd_byte = bus.dmem_rdata[7:0];
        endcase
        rd_half = addr_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

    // Outputs decoded from state; bus fields come from the latched operation.
    always_comb begin
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
        dbg_state      = state;
        load_data      = load_q;
        err            = err_q;
        bus.dmem_req   = (state == S_REQ);
        bus.dmem_we    = (state == S_REQ) && we_q;
        bus.dmem_addr  = {addr_q[31:2], 2'b00};
        bus.dmem_wstrb = ((state == S_REQ) && we_q) ? strb  : 4'b0000;
        bus.dmem_wdata = ((state == S_REQ) && we_q) ? wdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand-written reset/busy
// sequences and randomized operations checked against a reference model.
module tb_mem_access;

    localparam int TMO = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          delay;
        int          exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .bus(bus), .busy(busy), .done(done),
        .load_data(load_data), .err(err), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata, input int delay, input int exp_req,
                                input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                                input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
        v.delay = delay; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata; v.exp_load = exp_load;
        v.exp_err = exp_err;
        return v;
    endfunction

    // Reference model: derives the expected bus activity and result from the
    // operation's size, offset and ack delay with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] val;
        bit          bad;
        r = v;
        r.exp_req = 0; r.exp_addr = 0; r.exp_wstrb = 0; r.exp_wdata = 0;
        r.exp_load = 0; r.exp_err = 0;
        size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        bad = (v.rd && v.wr) || (v.f3 == 3'd3) || (v.f3 >= 3'd6);
`ifdef MISALIGN_TRAP_EN
        if ((v.rd || v.wr) && (v.addr % size) != 0) bad = 1'b1;
`endif
        if (bad) begin
            r.exp_err = 1'b1;
        end else if (v.rd || v.wr) begin
            off = ((int'(v.addr % 4)) / size) * size;
            r.exp_addr  = v.addr - (v.addr % 4);
            r.exp_wstrb = v.wr ? 4'(((1 << size) - 1) << off) : 4'h0;
            if (v.wr)
                r.exp_wdata = (size == 1) ? v.sd[7:0] * 32'h01010101 :
                              (size == 2) ? v.sd[15:0] * 32'h00010001 : v.sd;
            if (v.delay >= TMO) begin
                r.exp_req = TMO;
                r.exp_err = 1'b1;
            end else begin
                r.exp_req = v.delay + 1;
                if (!v.wr) begin
                    mask = (size == 4) ? 32'hFFFFFFFF : 32'((64'd1 << (8 * size)) - 64'd1);
                    val  = (v.rdata >> (8 * off)) & mask;
                    if (!v.f3[2] && size < 4 && val > (mask >> 1)) val = val | ~mask;
                    r.exp_load = val;
                end
            end
        end
        return r;
    endfunction

    // Driver + memory responder for one operation; optional noise drives
    // spurious start/ack outside the points where they would be honoured.
    task automatic run_op(input vec_t v, input string name, input bit noise);
        int          req_cycles = 0;
        bit          got_done = 0;
        logic [32:0] e;
        exp_q.push_back({v.exp_err, v.exp_load});
        @(negedge clk);
        start = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
        alu_result = v.addr; store_data = v.sd;
        bus.dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            bus.dmem_ack = 1'b0;
            if (done) begin
                got_done = 1;
                chk({name, " req_cycles"}, 32'(req_cycles), 32'(v.exp_req));
                chk({name, " req_low_at_done"}, {31'h0, bus.dmem_req}, 32'h0);
                e = exp_q.pop_front();
                chk({name, " load_data"}, load_data, e[31:0]);
                chk({name, " err"}, {31'h0, err}, {31'h0, e[32]});
                if (noise) bus.dmem_ack = 1'($urandom_range(0, 1));
            end else begin
                if (bus.dmem_req) begin
                    req_cycles++;
                    chk({name, " req_fields"},
                        {bus.dmem_addr[31:6], bus.dmem_we, bus.dmem_wstrb, 1'b0} ^ {bus.dmem_addr[5:0], 26'h0} ^ {26'h0, bus.dmem_addr[5:0]},
                        {v.exp_addr[31:6], v.wr, v.exp_wstrb, 1'b0} ^ {v.exp_addr[5:0], 26'h0} ^ {26'h0, v.exp_addr[5:0]});
                    chk({name, " dmem_addr"}, bus.dmem_addr, v.exp_addr);
                    chk({name, " dmem_wdata"}, bus.dmem_wdata, v.exp_wdata);
                    if (req_cycles == v.delay + 1) begin
                        bus.dmem_ack = 1'b1;
                        bus.dmem_rdata = v.rdata;
                    end else begin
                        bus.dmem_rdata = $urandom;
                    end
                    if (noise) begin
                        start = 1'($urandom_range(0, 1));
                        mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b111;
                        alu_result = $urandom; store_data = $urandom;
                    end
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!got_done) begin
            chk({name, " done_within_budget"}, 32'h0, 32'h1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk({name, " done_one_cycle"}, {30'h0, done, busy}, 32'h0);
        chk({name, " load_held"}, load_data, v.exp_load);
    endtask

    vec_t  tbl[12];
    string nm[12];
    vec_t  v;

    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;

        // Table: hand-computed expectations.
`ifdef MISALIGN_TRAP_EN
        tbl[0]  = mk(0, 1, 3'b010, 32'h1006, 32'hDEADBEEF, 32'h0, 2, 0, 0, 0, 0, 32'h0, 1);
        tbl[4]  = mk(1, 0, 3'b001, 32'h0001, 32'h0, 32'h80FF1234, 1, 0, 0, 0, 0, 32'h0, 1);
`else
        tbl[0]  = mk(0, 1, 3'b010, 32'h1006, 32'hDEADBEEF, 32'h0, 2, 3, 32'h1004, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        tbl[4]  = mk(1, 0, 3'b001, 32'h0001, 32'h0, 32'h80FF1234, 1, 2, 32'h0000, 4'h0, 32'h0, 32'h00001234, 0);
`endif
        nm[0] = "sw_1006"; nm[4] = "lh_0001";
        tbl[1]  = mk(1, 0, 3'b000, 32'h2003, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'h0, 32'h0, 32'hFFFFFF80, 0); nm[1]  = "lb_2003";
        tbl[2]  = mk(1, 0, 3'b100, 32'h2003, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'h0, 32'h0, 32'h00000080, 0); nm[2]  = "lbu_2003";
        tbl[3]  = mk(0, 1, 3'b000, 32'h2003, 32'h5A, 32'h0, 1, 2, 32'h2000, 4'h8, 32'h5A5A5A5A, 32'h0, 0);       nm[3]  = "sb_2003";
        tbl[5]  = mk(0, 0, 3'b010, 32'h4000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0);                             nm[5]  = "noop";
        tbl[6]  = mk(1, 1, 3'b010, 32'h4000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1);                             nm[6]  = "rd_and_wr";
        tbl[7]  = mk(1, 0, 3'b011, 32'h4000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1);                             nm[7]  = "funct3_011";
        tbl[8]  = mk(1, 0, 3'b010, 32'h5000, 32'h0, 32'hAAAA5555, 99, TMO, 32'h5000, 4'h0, 32'h0, 32'h0, 1);     nm[8]  = "lw_timeout";
        tbl[9]  = mk(1, 0, 3'b101, 32'h0002, 32'h0, 32'h80FF1234, 1, 2, 32'h0, 4'h0, 32'h0, 32'h000080FF, 0);    nm[9]  = "lhu_0002";
        tbl[10] = mk(1, 0, 3'b001, 32'h0002, 32'h0, 32'h80FF1234, 1, 2, 32'h0, 4'h0, 32'h0, 32'hFFFF80FF, 0);    nm[10] = "lh_0002";
        tbl[11] = mk(0, 1, 3'b001, 32'h0002, 32'h1234ABCD, 32'h0, 0, 1, 32'h0, 4'hC, 32'hABCDABCD, 32'h0, 0);    nm[11] = "sh_0002";

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_bus", {bus.dmem_req, bus.dmem_we, bus.dmem_wstrb, 26'h0}, 32'h0);
        chk("reset_addr", bus.dmem_addr, 32'h0);
        chk("reset_wdata", bus.dmem_wdata, 32'h0);
        chk("reset_status", {29'h0, busy, done, err}, 32'h0);
        chk("reset_load", load_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_op(tbl[i], nm[i], 1'b0);

        // Reset while a request is outstanding.
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h3000; store_data = 32'h0;
        @(negedge clk);
        start = 1'b0;
        chk("midreq_req_before_reset", {31'h0, bus.dmem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreq_req_dropped", {31'h0, bus.dmem_req}, 32'h0);
        chk("midreq_status", {29'h0, busy, done, err}, 32'h0);
        chk("midreq_load_cleared", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreq_not_completed", {30'h0, busy, done}, 32'h0);

        // After release: busy-time starts ignored, then an illegal op.
        run_op(mk(1, 0, 3'b010, 32'h3000, 32'h0, 32'h13572468, 2, 3, 32'h3000, 4'h0, 32'h0, 32'h13572468, 0),
               "lw_after_reset_noise", 1'b1);
        run_op(mk(1, 1, 3'b000, 32'h3000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1), "rd_wr_after_reset", 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            v.rd = 1'($urandom_range(0, 1));
            v.wr = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            if (v.wr && !v.rd && v.f3[2] && !v.f3[1]) v.f3[2] = 1'b0;
            v.addr  = $urandom;
            v.sd    = $urandom;
            v.rdata = $urandom;
            v.delay = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 2));
            run_op(model(v), $sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max REQ-state cycles awaiting dmem_ack before abort (range 1..65535).
REQ-002 SHALL have: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have: start  in  1  accept operation (sampled only when busy=0).
REQ-005 SHALL have: mem_read  in  1  load request; mem_write  in  1  store request.
REQ-006 SHALL have: funct3  in  3  access size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (sb/sh/sw use 000/001/010).
REQ-007 SHALL have: alu_result  in  32  byte address from ALU stage; store_data  in  32  rs2 value.
REQ-008 SHALL have: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned, bits[1:0]=00); dmem_wstrb  out  4; dmem_wdata  out  32.
REQ-009 SHALL have: dmem_rdata  in  32; dmem_ack  in  1  memory completion, valid only while dmem_req=1.
REQ-010 SHALL have: busy  out  1; done  out  1  one-cycle completion pulse; load_data  out  32; err  out  1  valid with done.

Function
REQ-011 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE; busy=1 in REQ and DONE.
REQ-012 SHALL, on edge with state IDLE and start=1, latch address, data, funct3, read/write, and enter REQ; dmem_req=1 from the following cycle.
REQ-013 SHALL hold dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata stable throughout REQ until dmem_ack=1 is sampled.
REQ-014 SHALL, on edge in REQ with dmem_ack=1, capture load_data, drop dmem_req, enter DONE; done=1 for exactly that DONE cycle; next edge -> IDLE.
REQ-015 SHALL ignore start while busy=1 and dmem_ack outside REQ.
REQ-016 SHALL treat start with mem_read=mem_write=0 as no-op: REQ skipped, DONE next cycle, load_data=0, err=0.
REQ-017 SHALL treat start with mem_read=mem_write=1, or funct3 in {011,110,111}, as illegal: no request, DONE next cycle, err=1, load_data=0.
REQ-018 SHALL count REQ cycles; when count reaches TIMEOUT_CYCLES without ack, drop dmem_req, enter DONE with err=1, load_data=0.
REQ-019 SHALL drive store lanes by a=addr[1:0]: byte wstrb=0001<<a, wdata={4{sd[7:0]}}; half wstrb=0011<<(2*a[1]), wdata={2{sd[15:0]}}; word wstrb=1111, wdata=sd; loads wstrb=0000.
REQ-020 SHALL extract loads: byte rdata[8a+7:8a], half rdata[16a[1]+15:16a[1]]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
REQ-021 SHALL register load_data and err; both held until next done.

Reset
REQ-022 SHALL on rst_n=0 immediately force state IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0, load_data=0, busy=0, done=0, err=0, timeout count=0.
REQ-023 SHALL abandon any in-flight access on reset without completing it; first start after release behaves as from power-up.

Configuration
REQ-024 SHALL, with MISALIGN_TRAP_EN defined, flag half with addr[0]=1 or word with addr[1:0]!=00: no request, DONE next cycle, err=1, load_data=0.
REQ-025 SHALL, with MISALIGN_TRAP_EN undefined, ignore addr[0] for half and addr[1:0] for word and perform the access with err=0.

Verification
REQ-026 SHALL test sw: addr 0x1006, sd 0xDEADBEEF, ack after 3 cycles -> dmem_addr 0x1004, wstrb 1111, wdata 0xDEADBEEF, done 1 cycle after ack edge, err=0.
REQ-027 SHALL test lb/lbu: addr 0x2003, rdata 0x80FF1234 -> lb load_data 0xFFFFFF80, lbu 0x00000080; sb addr 0x2003 sd 0x5A -> wstrb 1000, wdata 0x5A5A5A5A.
REQ-028 SHALL test timeout: TIMEOUT_CYCLES=4, lw with ack held 0 -> dmem_req high exactly 4 cycles, done with err=1, load_data 0.
REQ-029 SHALL test misalign: lh addr 0x0001 -> with MISALIGN_TRAP_EN err=1 and no dmem_req; without, dmem_addr 0x0000, wstrb 0000, low half extracted, err=0.
REQ-030 SHALL test reset mid-REQ: assert rst_n=0 while dmem_req=1 -> dmem_req=0 same cycle, busy=0; start asserted during busy ignored, mem_read=mem_write=1 -> err=1.
